port_link: RTL
==============

# port_link

Responder end of the CPU `port` handshake: a buffered, blocking word channel between a writing CPU and a reading CPU. The writer pushes words with a stall-on-full handshake. The reader issues a level request and is served by a small FSM that waits while the buffer is empty. It sits between two `cpu` instances, or between a `cpu` and an I/O agent. The CPU derives `stall` from the link's `rd_valid`/`wr_stall` signals.

## Interface
- `WORD_SIZE`, default 8: data width in bits.
- `DEPTH`, default 4: buffer entries; power of two, at least 2.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `wr_en` in 1: writer offers `wr_data` this cycle.
- `wr_data` in WORD_SIZE: word to write.
- `wr_stall` out 1: buffer full, so `wr_en` is ignored; combinational from count.
- `write_finish` out 1: one-cycle pulse; a word was accepted on the previous edge.
- `rd_req` in 1: level; reader wants a word.
- `read_start` out 1: one-cycle pulse; a new read request was registered.
- `rd_valid` out 1: `rd_data` holds a delivered word this cycle.
- `rd_data` out WORD_SIZE: delivered word; holds its last value when `rd_valid` is 0.
- `count` out clog2(DEPTH+1): words currently buffered.

## Operation
- Storage is a circular buffer with wr_ptr and rd_ptr, each clog2(DEPTH) bits and wrapping modulo DEPTH, plus a separate count register; full is count==DEPTH, empty is count==0.
- Push: on an edge with `wr_en` and not full, write `mem[wr_ptr]`, increment wr_ptr, and set `write_finish` to 1 for the next cycle.
- When full, `wr_en` is dropped silently: no state change and no `write_finish`. The writer must hold the word until `wr_stall` falls.
- Read FSM has three states: IDLE, WAIT and DATA.
  - IDLE with `rd_req`, not empty: pop into `rd_data`, go to DATA, pulse `read_start`.
  - IDLE with `rd_req`, empty: go to WAIT, pulse `read_start`.
  - IDLE without `rd_req`: stay.
  - WAIT with `rd_req` dropped: go to IDLE (abort, nothing popped).
  - WAIT with `rd_req` held, not empty: pop, go to DATA.
  - WAIT with `rd_req` held, empty: stay.
  - DATA: `rd_valid` is 1.
    - `rd_req` held and not empty: pop again and stay in DATA (back-to-back, one word per cycle, no new `read_start`).
    - `rd_req` held and empty: go to WAIT.
    - `rd_req` low: go to IDLE.
- Pop means `rd_data` <= `mem[rd_ptr]`, rd_ptr + 1, count − 1.
- Simultaneous push and pop in one edge: count is unchanged, and both pointers advance.
- Push while full with a pop in the same edge is still refused; `wr_stall` is decided from the pre-edge count.
- No bypass: a word pushed into an empty buffer is poppable at the earliest on the following edge.
- `count` arithmetic: a push alone adds 1, a pop alone subtracts 1, both together leave it unchanged; it never exceeds DEPTH and never underflows.

## Timing
- Reset values (immediate on `rst_n` low, independent of `clk`):
  - FSM in IDLE; pointers 0; `count` 0.
  - `rd_valid`, `read_start` and `write_finish` all 0.
  - `rd_data` 0; `wr_stall` 0.
  - `mem` contents are not reset.
- Reset mid-operation discards all buffered words and any pending request. After release, the reader must re-raise `rd_req` (a held `rd_req` counts as new and pulses `read_start`).
- Write latency: `wr_en` at edge N gives `write_finish` high during cycle N+1 and `count` updated after edge N.
- Read latency:
  - Non-empty buffer, `rd_req` sampled at edge N: `rd_valid` and `rd_data` during cycle N+1.
  - Empty buffer: `rd_valid` follows one cycle after the edge that first sees count>0 while in WAIT.
- Throughput: one push and one pop per cycle sustained.
- All outputs are registered except `wr_stall` and `count`, which are decoded from registers; there are no combinational input-to-output paths.

## Test plan
- Reset then push 0x11, 0x22, 0x33 and hold `rd_req`: `read_start` pulses once; `rd_valid` for 3 consecutive cycles with 0x11, 0x22, 0x33; `count` 3→0; then WAIT.
- With DEPTH=4, push 0xA0–0xA4 back-to-back and no reads: 4 `write_finish` pulses; `wr_stall`=1 after the 4th; 0xA4 is dropped; `count`=4; reading then yields 0xA0–0xA3.
- With the buffer empty, raise `rd_req` and 3 cycles later push 0x5C: WAIT for those cycles; `rd_valid` with 0x5C exactly 2 cycles after the push edge.
- In WAIT, drop `rd_req`, then push 0x77: FSM returns to IDLE; no `rd_valid`; `count`=1; a later request returns 0x77 with a fresh `read_start`.
- Run 10 cycles of simultaneous push and pop with count held at 2 (including pointer wrap past 3→0): data order preserved; `count` stays 2.
- Assert `rst_n` low asynchronously mid-burst with `count`=3 and in DATA: `rd_valid`, `write_finish` and `count` go to 0 before the next edge; after release, the buffer is empty and FSM is in IDLE.

Source files
------------

// File: rtl/port_link.sv
// Responder end of the CPU port handshake: a circular word buffer between a
// stall-on-full writer and a level-request reader served by a small read FSM.
module port_link #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WORD_SIZE-1:0]         wr_data,
    output logic                         wr_stall,
    output logic                         write_finish,
    input  logic                         rd_req,
    output logic                         read_start,
    output logic                         rd_valid,
    output logic [WORD_SIZE-1:0]         rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [1:0]                   link_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic start;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign wr_stall   = full;
    assign push       = wr_en && !full;
    assign link_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (rd_req) next_state = empty ? WAIT : DATA;
            WAIT: begin
                if (!rd_req)     next_state = IDLE;
                else if (!empty) next_state = DATA;
            end
            DATA: begin
                if (!rd_req)    next_state = IDLE;
                else if (empty) next_state = WAIT;
            end
            default: next_state = IDLE;
        endcase
    end

    // A pop happens on any edge where the reader wants a word and one is stored;
    // only the IDLE exit counts as a new request.
    always_comb begin
        pop   = 1'b0;
        start = 1'b0;
        case (state)
            IDLE: begin
                start = rd_req;
                pop   = rd_req && !empty;
            end
            WAIT:    pop = rd_req && !empty;
            DATA:    pop = rd_req && !empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            read_start   <= 1'b0;
            write_finish <= 1'b0;
        end else begin
            write_finish <= push;
            read_start   <= start;
            rd_valid     <= pop;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
